// File: rtl/id_operand_stage.sv
// ID operand stage: resolves two source operands (register file or forwarding),
// detects load-use hazards and holds the ID/EX pipeline register.
module id_operand_stage #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int FWD_N    = 2,
    parameter int CTRL_W   = 6,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dec_valid_i,
    input  logic [CTRL_W-1:0]         dec_ctrl_i,
    input  logic                      dec_we_i,
    input  logic [ADDR_W-1:0]         dec_waddr_i,
    input  logic [1:0]                re_i,
    input  logic [2*ADDR_W-1:0]       raddr_i,
    input  logic [2*DATA_W-1:0]       rf_data_i,
    input  logic [FWD_N-1:0]          fwd_we_i,
    input  logic [FWD_N-1:0]          fwd_load_i,
    input  logic [FWD_N*ADDR_W-1:0]   fwd_waddr_i,
    input  logic [FWD_N*DATA_W-1:0]   fwd_wdata_i,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic                      clr_cnt_i,
    output logic                      stall_req_o,
    output logic                      valid_o,
    output logic [CTRL_W-1:0]         ctrl_o,
    output logic                      we_o,
    output logic [ADDR_W-1:0]         waddr_o,
    output logic [2*DATA_W-1:0]       op_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    logic [DATA_W-1:0] res_op [2];
    logic [1:0]        hazard;

    // Source 0 is the youngest, so the first hit while scanning upward wins.
    for (genvar k = 0; k < 2; k++) begin : g_opnd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;
        logic              haz;
        logic              hit;

        assign addr = raddr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            val = '0;
            haz = 1'b0;
            hit = 1'b0;
            if (re_i[k] && !(ZERO_REG != 0 && addr == '0)) begin
                val = rf_data_i[k*DATA_W +: DATA_W];
                for (int j = 0; j < FWD_N; j++) begin
                    if (!hit && fwd_we_i[j] && fwd_waddr_i[j*ADDR_W +: ADDR_W] == addr) begin
                        hit = 1'b1;
                        if (fwd_load_i[j]) begin
                            haz = 1'b1;
                        end else begin
                            val = fwd_wdata_i[j*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end

        assign res_op[k] = val;
        assign hazard[k] = haz;
    end

    assign stall_req_o = dec_valid_i & (|hazard);

    logic                bubble;
    logic                valid_d, valid_q;
    logic [CTRL_W-1:0]   ctrl_d, ctrl_q;
    logic                we_d, we_q;
    logic [ADDR_W-1:0]   waddr_d, waddr_q;
    logic [2*DATA_W-1:0] op_d, op_q;
    logic [CNT_W-1:0]    stall_cnt_q;

    assign bubble = stall_req_o & ~hold_i & ~flush_i;

    // Flush and bubble both load an empty slot; hold simply blocks the load.
    always_comb begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        we_d    = 1'b0;
        waddr_d = '0;
        op_d    = '0;
        if (!flush_i && !stall_req_o) begin
            valid_d = dec_valid_i;
            we_d    = dec_we_i & dec_valid_i;
            waddr_d = dec_waddr_i;
            if (dec_valid_i) begin
                ctrl_d = dec_ctrl_i;
                op_d   = {res_op[1], res_op[0]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            op_q    <= '0;
        end else if (flush_i || !hold_i) begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            op_q    <= op_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            stall_cnt_q <= '0;
        end else if (bubble && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign valid_o     = valid_q;
    assign ctrl_o      = ctrl_q;
    assign we_o        = we_q;
    assign waddr_o     = waddr_q;
    assign op_o        = op_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
